// File: rtl/acc_arb_pkg.sv
// Shared constants and types for the accumulator arbiter.
// The lock state type is only used when ACC_ARB_LOCK_EN is defined.
package acc_arb_pkg;

  localparam int NREQ = 2;

  // Register offsets of the accumulator peripheral (daddr[3:2]).
  localparam logic [1:0] ACC_CLR = 2'd0;
  localparam logic [1:0] ACC_ADD = 2'd1;
  localparam logic [1:0] ACC_SUM = 2'd2;
  localparam logic [1:0] ACC_CNT = 2'd3;

  typedef struct packed {
    logic valid;
    logic idx;
  } rd_tag_t;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_R0   = 2'd1,
    LOCK_R1   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/acc_arb_if.sv
// Requester-side bus of the accumulator arbiter, both requesters packed side by side.
// req_lock exists only when ACC_ARB_LOCK_EN is defined.
interface acc_arb_if
  import acc_arb_pkg::*;
#(
  parameter int DW = 32
) ();

  logic [NREQ-1:0]    req_ce;
  logic [4*NREQ-1:0]  req_we;
  logic [2*NREQ-1:0]  req_addr;
  logic [DW*NREQ-1:0] req_wdata;
`ifdef ACC_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;
`endif
  logic [NREQ-1:0]    req_gnt;
  logic [NREQ-1:0]    req_rvalid;
  logic [DW-1:0]      req_rdata;

  modport master (
    output req_ce, req_we, req_addr, req_wdata,
`ifdef ACC_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_gnt, req_rvalid, req_rdata
  );

  modport slave (
    input  req_ce, req_we, req_addr, req_wdata,
`ifdef ACC_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_gnt, req_rvalid, req_rdata
  );

endinterface

// File: rtl/acc_arb_rr.sv
// Round-robin grant decision with last-winner memory and, under ACC_ARB_LOCK_EN,
// a lock owner that excludes the other requester until its lock request drops.
module acc_arb_rr
  import acc_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] ce,
`ifdef ACC_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  output logic [NREQ-1:0] gnt
);

  logic last_gnt_reg;

`ifdef ACC_ARB_LOCK_EN
  lock_state_t lock_reg;
  logic        owned;
  logic        owner;

  assign owned = (lock_reg != LOCK_NONE);
  assign owner = (lock_reg == LOCK_R1);
`endif

  // Grant is combinational so a requester can be served in the cycle it asks.
  always_comb begin
    gnt = '0;
    if (!reset) begin
`ifdef ACC_ARB_LOCK_EN
      if (owned)
        gnt[owner] = ce[owner];
      else if (&ce)
        gnt[~last_gnt_reg] = 1'b1;
      else
        gnt = ce;
`else
      if (&ce)
        gnt[~last_gnt_reg] = 1'b1;
      else
        gnt = ce;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_reg <= 1'b0;
`ifdef ACC_ARB_LOCK_EN
      lock_reg     <= LOCK_NONE;
`endif
    end else begin
      if (|gnt)
        last_gnt_reg <= gnt[1];
`ifdef ACC_ARB_LOCK_EN
      // Release on the first edge where the owner stops asking, granted or not.
      if (owned) begin
        if (!lock[owner])
          lock_reg <= LOCK_NONE;
      end else if (|gnt && lock[gnt[1]]) begin
        lock_reg <= gnt[1] ? LOCK_R1 : LOCK_R0;
      end
`endif
    end
  end

endmodule

// File: rtl/acc_arbiter.sv
// Shares the accumulator between two bus masters: round-robin grant, winner mux,
// and return of one-cycle-late read data. Optional locking via ACC_ARB_LOCK_EN.
module acc_arbiter
  import acc_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  acc_arb_if.slave      bus,
  output logic          acc_ce,
  output logic          acc_we,
  output logic [1:0]    acc_addr,
  output logic [DW-1:0] acc_wdata,
  input  logic [DW-1:0] acc_rdata
);

  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [3:0]      we_m    [NREQ];
  logic [1:0]      addr_m  [NREQ];
  logic [DW-1:0]   wdata_m [NREQ];
  logic [3:0]      we_any;
  logic [1:0]      addr_any;
  logic [DW-1:0]   wdata_any;
  rd_tag_t         rd_tag_reg;

  acc_arb_rr u_rr (
    .clk   (clk),
    .reset (reset),
    .ce    (bus.req_ce),
`ifdef ACC_ARB_LOCK_EN
    .lock  (bus.req_lock),
`endif
    .gnt   (gnt)
  );

  // Each requester's fields are masked by its grant, so an OR of all lanes is the winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign we_m[gi]    = gnt[gi] ? bus.req_we[4*gi +: 4]     : 4'b0;
    assign addr_m[gi]  = gnt[gi] ? bus.req_addr[2*gi +: 2]   : 2'b0;
    assign wdata_m[gi] = gnt[gi] ? bus.req_wdata[DW*gi +: DW] : '0;
    assign rvalid[gi]  = rd_tag_reg.valid && (rd_tag_reg.idx == 1'(gi));
  end

  always_comb begin
    we_any    = '0;
    addr_any  = '0;
    wdata_any = '0;
    for (int i = 0; i < NREQ; i++) begin
      we_any    = we_any | we_m[i];
      addr_any  = addr_any | addr_m[i];
      wdata_any = wdata_any | wdata_m[i];
    end
  end

  assign acc_ce     = |gnt;
  assign acc_we     = |we_any;
  assign acc_addr   = addr_any;
  assign acc_wdata  = wdata_any;

  assign bus.req_gnt    = gnt;
  assign bus.req_rvalid = rvalid;
  assign bus.req_rdata  = rd_tag_reg.valid ? acc_rdata : '0;

  // A granted access with no byte enables is a read; remember who issued it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tag_reg <= '0;
    end else begin
      rd_tag_reg.valid <= acc_ce && !acc_we;
      rd_tag_reg.idx   <= gnt[1];
    end
  end

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed bench for acc_arbiter: a cycle-level reference model plus literal pins.
// Lock checks are pinned only when ACC_ARB_LOCK_EN is defined.
module tb_acc_arbiter;
  import acc_arb_pkg::*;

  localparam int DW = 32;
`ifdef ACC_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          acc_ce, acc_we;
  logic [1:0]    acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [DW-1:0] acc_rdata;

  acc_arb_if #(.DW(DW)) bus ();

  acc_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .acc_ce    (acc_ce),
    .acc_we    (acc_we),
    .acc_addr  (acc_addr),
    .acc_wdata (acc_wdata),
    .acc_rdata (acc_rdata)
  );

  always #5 clk = ~clk;

  // Accumulator peripheral stand-in: CLR, ADD, SUM, CNT with one-cycle read latency.
  logic [DW-1:0] emu_sum, emu_cnt;
  always @(posedge clk) begin
    if (reset) begin
      emu_sum   <= '0;
      emu_cnt   <= '0;
      acc_rdata <= 32'hDEAD_BEEF;
    end else begin
      acc_rdata <= 32'hDEAD_BEEF;
      if (acc_ce && !acc_we)
        acc_rdata <= (acc_addr == ACC_SUM) ? emu_sum : (acc_addr == ACC_CNT) ? emu_cnt : '0;
      if (acc_ce && acc_we && acc_addr == ACC_CLR) begin
        emu_sum <= '0;
        emu_cnt <= '0;
      end
      if (acc_ce && acc_we && acc_addr == ACC_ADD) begin
        emu_sum <= emu_sum + acc_wdata;
        emu_cnt <= emu_cnt + 1;
      end
    end
  end

  typedef struct {
    logic          rst;
    logic [1:0]    ce;
    logic [3:0]    we0, we1;
    logic [1:0]    a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    lock;
    int            lg;   // literal req_gnt this cycle, -1 = none
    int            lrv;  // literal req_rvalid this cycle, -1 = none
    logic [DW-1:0] lrd;  // literal req_rdata when lrv >= 0
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur   = 0;
  bit   active = 1'b0;

  function automatic vec_t mk(logic rst, logic [1:0] ce,
                              logic [3:0] we0, logic [1:0] a0, logic [DW-1:0] d0,
                              logic [3:0] we1, logic [1:0] a1, logic [DW-1:0] d1,
                              logic [1:0] lock, int lg, int lrv, logic [DW-1:0] lrd);
    vec_t v;
    v.rst = rst; v.ce = ce; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.we1 = we1; v.a1 = a1; v.d1 = d1; v.lock = lock;
    v.lg = lg; v.lrv = lrv; v.lrd = lrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cur, act, exp);
    end
  endtask

  // Reference model state: what the arbiter and accumulator must hold after each edge.
  int            m_last  = 0;
  int            m_owner = -1;
  bit            m_pend  = 1'b0;
  int            m_pidx  = 0;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] m_sum   = '0;
  logic [DW-1:0] m_cnt   = '0;

  always @(negedge clk) begin
    if (active) begin
      vec_t          v;
      int            win;
      logic [3:0]    we;
      logic [1:0]    ad;
      logic [DW-1:0] wd;
      logic [1:0]    e_gnt, e_rv;
      logic [DW-1:0] e_rd;
      v   = vecs[cur];
      win = -1;
      if (!v.rst) begin
        if (m_owner >= 0)       win = v.ce[m_owner] ? m_owner : -1;
        else if (v.ce == 2'b11) win = 1 - m_last;
        else if (v.ce[0])       win = 0;
        else if (v.ce[1])       win = 1;
      end
      we    = (win == 0) ? v.we0 : (win == 1) ? v.we1 : 4'b0;
      ad    = (win == 0) ? v.a0  : (win == 1) ? v.a1  : 2'b0;
      wd    = (win == 0) ? v.d0  : (win == 1) ? v.d1  : '0;
      e_gnt = (win < 0) ? 2'b00 : (win == 0) ? 2'b01 : 2'b10;
      e_rv  = !m_pend ? 2'b00 : (m_pidx == 0) ? 2'b01 : 2'b10;
      e_rd  = m_pend ? m_pdata : '0;

      $display("cyc %0d rst=%0b ce=%b gnt=%b acc_ce=%0b acc_we=%0b addr=%0d wdata=%0h rvalid=%b rdata=%0h",
               cur, v.rst, v.ce, bus.req_gnt, acc_ce, acc_we, acc_addr, acc_wdata,
               bus.req_rvalid, bus.req_rdata);

      chk("req_gnt",    64'(bus.req_gnt),    64'(e_gnt));
      chk("acc_ce",     64'(acc_ce),         64'(win >= 0));
      chk("acc_we",     64'(acc_we),         64'(|we));
      chk("acc_addr",   64'(acc_addr),       64'(ad));
      chk("acc_wdata",  64'(acc_wdata),      64'(wd));
      chk("req_rvalid", 64'(bus.req_rvalid), 64'(e_rv));
      chk("req_rdata",  64'(bus.req_rdata),  64'(e_rd));
      if (v.lg >= 0)
        chk("pin_gnt", 64'(bus.req_gnt), 64'(v.lg));
      if (v.lrv >= 0) begin
        chk("pin_rvalid", 64'(bus.req_rvalid), 64'(v.lrv));
        chk("pin_rdata",  64'(bus.req_rdata),  64'(v.lrd));
      end

      if (v.rst) begin
        m_last = 0; m_owner = -1; m_pend = 1'b0; m_sum = '0; m_cnt = '0;
      end else begin
        m_pend = (win >= 0) && (we == 4'b0);
        m_pidx = win;
        m_pdata = (ad == ACC_SUM) ? m_sum : (ad == ACC_CNT) ? m_cnt : '0;
        if (win >= 0 && we != 4'b0 && ad == ACC_CLR) begin
          m_sum = '0; m_cnt = '0;
        end
        if (win >= 0 && we != 4'b0 && ad == ACC_ADD) begin
          m_sum = m_sum + wd; m_cnt = m_cnt + 1;
        end
        if (win >= 0) m_last = win;
        if (LOCK_ON) begin
          if (m_owner >= 0) begin
            if (!v.lock[m_owner]) m_owner = -1;
          end else if (win >= 0 && v.lock[win]) begin
            m_owner = win;
          end
        end
      end
    end
  end

  initial begin
    // Reset in a conflict cycle, then conflicts, single read, read-then-write, partial BE.
    vecs.push_back(mk(1, 2'b11, 4'hF, 0, 0,        4'hF, 0, 0, 2'b00,  0, -1, 0));
    vecs.push_back(mk(0, 2'b11, 4'h0, 3, 0,        4'hF, 1, 5, 2'b00,  2,  0, 0));
    vecs.push_back(mk(0, 2'b11, 4'h0, 3, 0,        4'hF, 1, 5, 2'b00,  1, -1, 0));
    vecs.push_back(mk(0, 2'b11, 4'hF, 0, 0,        4'hF, 1, 5, 2'b00,  2,  1, 1));
    vecs.push_back(mk(0, 2'b01, 4'hF, 0, 0,        4'h0, 0, 0, 2'b00,  1, -1, 0));
    vecs.push_back(mk(0, 2'b01, 4'hF, 1, 'h1234,   4'h0, 0, 0, 2'b00, -1, -1, 0));
    vecs.push_back(mk(0, 2'b01, 4'h0, 2, 0,        4'h0, 0, 0, 2'b00,  1, -1, 0));
    vecs.push_back(mk(0, 2'b10, 4'h0, 0, 0,        4'hF, 0, 0, 2'b00,  2,  1, 'h1234));
    vecs.push_back(mk(0, 2'b10, 4'h0, 0, 0,        4'h2, 1, 9, 2'b00,  2,  0, 0));
    vecs.push_back(mk(0, 2'b00, 4'h0, 0, 0,        4'h0, 0, 0, 2'b00, -1,  0, 0));
    vecs.push_back(mk(0, 2'b10, 4'h0, 0, 0,        4'h0, 0, 0, 2'b00,  2, -1, 0));
    vecs.push_back(mk(0, 2'b00, 4'h0, 0, 0,        4'h0, 0, 0, 2'b00, -1,  2, 0));
    // Read just before reset still returns in the reset cycle; first conflict after goes to req1.
    vecs.push_back(mk(0, 2'b01, 4'h0, 2, 0,        4'h0, 0, 0, 2'b00,  1, -1, 0));
    vecs.push_back(mk(1, 2'b11, 4'h0, 3, 0,        4'h0, 2, 0, 2'b00,  0,  1, 9));
    vecs.push_back(mk(0, 2'b11, 4'h0, 3, 0,        4'h0, 2, 0, 2'b00,  2, -1, 0));
    vecs.push_back(mk(0, 2'b11, 4'h0, 3, 0,        4'h0, 2, 0, 2'b00,  1,  2, 0));
    vecs.push_back(mk(0, 2'b00, 4'h0, 0, 0,        4'h0, 0, 0, 2'b00, -1,  1, 0));
    // Locked CLR, ADD 3, ADD 4, read SUM by req0 while req1 keeps asking.
    vecs.push_back(mk(0, 2'b01, 4'hF, 0, 0,        4'h0, 0, 0, 2'b01, LOCK_ON ? 1 : -1, -1, 0));
    vecs.push_back(mk(0, 2'b11, 4'hF, 1, 3,        4'h0, 3, 0, 2'b01, LOCK_ON ? 1 : -1, -1, 0));
    vecs.push_back(mk(0, 2'b11, 4'hF, 1, 4,        4'h0, 3, 0, 2'b01, LOCK_ON ? 1 : -1, -1, 0));
    vecs.push_back(mk(0, 2'b11, 4'h0, 2, 0,        4'h0, 3, 0, 2'b01, LOCK_ON ? 1 : -1, -1, 0));
    vecs.push_back(mk(0, 2'b10, 4'h0, 0, 0,        4'h0, 3, 0, 2'b00, LOCK_ON ? 0 : -1, LOCK_ON ? 1 : -1, 7));
    vecs.push_back(mk(0, 2'b10, 4'h0, 0, 0,        4'h0, 3, 0, 2'b00, LOCK_ON ? 2 : -1, -1, 0));
    vecs.push_back(mk(0, 2'b00, 4'h0, 0, 0,        4'h0, 0, 0, 2'b00, -1, LOCK_ON ? 2 : -1, 2));

    reset = 1'b1;
    bus.req_ce = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
`ifdef ACC_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      cur           = i;
      reset         = vecs[i].rst;
      bus.req_ce    = vecs[i].ce;
      bus.req_we    = {vecs[i].we1, vecs[i].we0};
      bus.req_addr  = {vecs[i].a1, vecs[i].a0};
      bus.req_wdata = {vecs[i].d1, vecs[i].d0};
`ifdef ACC_ARB_LOCK_EN
      bus.req_lock  = vecs[i].lock;
`endif
      active = 1'b1;
      @(posedge clk);
    end
    #1;
    active = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
